// File: rtl/pll_seq_pkg.sv
// Package for the PLL lock sequencer.
// Holds the FSM state encoding and the width helpers shared by the top
// level and the bench.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } seq_state_e;

  // One shared counter serves all three timed phases. It only ever has to
  // reach (max - 1), so $clog2 of the largest phase length is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Retry counter width. The floor of 1 keeps MAX_RETRY=0 legal.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high clear
//   d_i    asynchronous input
//   q_o    synchronized output, delayed by STAGES clocks
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= '0;
    else       ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer. It pulses the PLL reset, waits for lock, and
// requires lock to stay up for a qualification window. Only then does it
// release the core reset. A lock timeout triggers a retry, up to MAX_RETRY
// times, and the block then parks in FAIL until software asks for a relock.
// If lock is lost while running, or software requests a relock, the whole
// sequence runs again.
// Ports:
//   refclk      reference clock (all logic on the rising edge)
//   rst         synchronous active-high reset
//   pll_locked  PLL lock indicator, asynchronous to refclk
//   relock_req  request a full re-sequence (honoured in RUN/FAIL only)
//   relock_ack  one-cycle pulse when relock_req is accepted
//   pll_rst     PLL reset
//   core_reset  core reset, held until lock is qualified
//   ready       lock qualified, core running
//   fail        sticky: retries exhausted
//   retry_cnt   retries used in the current sequence
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC = 16,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int STABLE_CYC   = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                              refclk,
  input  logic                              rst,
  input  logic                              pll_locked,
  input  logic                              relock_req,
  output logic                              relock_ack,
  output logic                              pll_rst,
  output logic                              core_reset,
  output logic                              ready,
  output logic                              fail,
  output logic [retry_width(MAX_RETRY)-1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_HOLD_CYC, LOCK_TIMEOUT, STABLE_CYC);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Outputs are assigned next to each state change, so they flip on the
  // same edge as state_q and never pass through a combinational decode.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      relock_ack <= 1'b0;
    end else begin
      relock_ack <= 1'b0;
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          if (locked_s) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == WAIT_LAST) begin
            cnt_q <= '0;
            if (retry_cnt == RETRY_MAX) begin
              state_q <= ST_FAIL;
              fail    <= 1'b1;
            end else begin
              state_q   <= ST_HOLD;
              retry_cnt <= retry_cnt + RW'(1);
              pll_rst   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STABLE: begin
          // A glitch in lock sends us back to WAIT with a fresh timeout.
          // It is not charged as a retry.
          if (!locked_s) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            core_reset <= 1'b0;
            ready      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          // relock_req takes priority so that it is still acknowledged
          // when it coincides with a loss of lock.
          if (relock_req || !locked_s) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            relock_ack <= relock_req;
          end
        end
        ST_FAIL: begin
          if (relock_req) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            fail       <= 1'b0;
            relock_ack <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
          pll_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer. Expected output values are queued against
// absolute cycle numbers when the stimulus is planned. They are popped and
// compared on the falling edge of the cycle they belong to.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst, pll_locked, relock_req;
  logic       relock_ack, pll_rst, core_reset, ready, fail;
  logic [1:0] retry_cnt;

  pll_lock_sequencer #(
    .RST_HOLD_CYC(4), .LOCK_TIMEOUT(64), .STABLE_CYC(8),
    .MAX_RETRY(2), .SYNC_STAGES(2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .relock_ack (relock_ack),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 refclk = ~refclk;

  localparam int F_ACK = 0, F_PRST = 1, F_CRST = 2, F_RDY = 3,
                 F_FAIL = 4, F_RETRY = 5, F_ACKS = 6;

  typedef struct {
    int    cyc;
    string tag;
    int    fld;
    int    val;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  base = 0;
  int  ack_cnt = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input int exp_v);
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
  endtask

  function automatic logic [31:0] fval(input int f);
    case (f)
      F_ACK:   return {31'd0, relock_ack};
      F_PRST:  return {31'd0, pll_rst};
      F_CRST:  return {31'd0, core_reset};
      F_RDY:   return {31'd0, ready};
      F_FAIL:  return {31'd0, fail};
      F_RETRY: return {30'd0, retry_cnt};
      default: return ack_cnt;
    endcase
  endfunction

  // Sorted insert so the queue head is always the earliest expectation.
  task automatic sb_push(input int dc, input string tag, input int f, input int v);
    sb_t e;
    int  i;
    e.cyc = base + dc; e.tag = tag; e.fld = f; e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_to(input int dc);
    while (cyc < base + dc) @(negedge refclk);
  endtask

  task automatic push_reset_vals(input int dc, input string pfx);
    sb_push(dc, {pfx, "_prst"},  F_PRST,  1);
    sb_push(dc, {pfx, "_crst"},  F_CRST,  1);
    sb_push(dc, {pfx, "_rdy"},   F_RDY,   0);
    sb_push(dc, {pfx, "_fail"},  F_FAIL,  0);
    sb_push(dc, {pfx, "_ack"},   F_ACK,   0);
    sb_push(dc, {pfx, "_retry"}, F_RETRY, 0);
  endtask

  always @(negedge refclk) begin
    if (relock_ack === 1'b1) ack_cnt++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.tag, fval(e.fld), e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge refclk);

    // A: power-up. Reset released at base+1, lock rises 5 cycles later.
    base = cyc;
    push_reset_vals(1, "A_rst");
    sb_push(4,  "A_prst_hi", F_PRST, 1);
    sb_push(5,  "A_prst_lo", F_PRST, 0);
    sb_push(16, "A_rdy_pre", F_RDY,  0);
    sb_push(16, "A_crst_pre", F_CRST, 1);
    sb_push(17, "A_rdy",     F_RDY,  1);
    sb_push(17, "A_crst",    F_CRST, 0);
    sb_push(17, "A_prst",    F_PRST, 0);
    sb_push(20, "A_acks",    F_ACKS, 0);
    wait_to(1);  rst = 1'b0;
    wait_to(6);  pll_locked = 1'b1;
    wait_to(22);

    // B: relock request in RUN, held through HOLD/WAIT/STABLE.
    base = cyc;
    sb_push(1,  "B_ack",     F_ACK,   1);
    sb_push(1,  "B_rdy0",    F_RDY,   0);
    sb_push(1,  "B_crst1",   F_CRST,  1);
    sb_push(1,  "B_prst1",   F_PRST,  1);
    sb_push(2,  "B_ack_end", F_ACK,   0);
    sb_push(4,  "B_prst_hi", F_PRST,  1);
    sb_push(5,  "B_prst_lo", F_PRST,  0);
    sb_push(13, "B_rdy_pre", F_RDY,   0);
    sb_push(14, "B_rdy",     F_RDY,   1);
    sb_push(16, "B_acks",    F_ACKS,  1);
    relock_req = 1'b1;
    wait_to(8);  relock_req = 1'b0;
    wait_to(18);

    // C: lock loss and relock_req in the same RUN cycle. Lock then stays
    // down, so the sequence times out through every retry into FAIL.
    base = cyc;
    pll_locked = 1'b0;
    sb_push(2,   "C_rdy_hold", F_RDY,   1);
    sb_push(3,   "C_ack",      F_ACK,   1);
    sb_push(3,   "C_rdy0",     F_RDY,   0);
    sb_push(3,   "C_prst1",    F_PRST,  1);
    sb_push(4,   "C_ack_end",  F_ACK,   0);
    sb_push(4,   "C_acks",     F_ACKS,  2);
    sb_push(6,   "C_p1_hi",    F_PRST,  1);
    sb_push(7,   "C_p1_lo",    F_PRST,  0);
    sb_push(70,  "C_gap1_end", F_PRST,  0);
    sb_push(70,  "C_retry0",   F_RETRY, 0);
    sb_push(71,  "C_p2_start", F_PRST,  1);
    sb_push(71,  "C_retry1",   F_RETRY, 1);
    sb_push(74,  "C_p2_hi",    F_PRST,  1);
    sb_push(75,  "C_p2_lo",    F_PRST,  0);
    sb_push(138, "C_gap2_end", F_RETRY, 1);
    sb_push(139, "C_p3_start", F_PRST,  1);
    sb_push(139, "C_retry2",   F_RETRY, 2);
    sb_push(143, "C_p3_lo",    F_PRST,  0);
    sb_push(206, "C_fail_pre", F_FAIL,  0);
    sb_push(207, "C_fail",     F_FAIL,  1);
    sb_push(207, "C_fail_rty", F_RETRY, 2);
    sb_push(207, "C_fail_prst", F_PRST, 0);
    sb_push(207, "C_fail_crst", F_CRST, 1);
    sb_push(207, "C_fail_rdy", F_RDY,   0);
    sb_push(300, "C_park_fail", F_FAIL, 1);
    sb_push(300, "C_park_prst", F_PRST, 0);
    sb_push(300, "C_park_crst", F_CRST, 1);
    sb_push(300, "C_park_rty", F_RETRY, 2);
    wait_to(2);  relock_req = 1'b1;
    wait_to(3);  relock_req = 1'b0;
    wait_to(300);

    // D: relock out of FAIL, one timeout, then lock with a one-cycle
    // glitch in STABLE that forces a full requalification.
    base = cyc;
    sb_push(1,  "D_ack",      F_ACK,   1);
    sb_push(1,  "D_fail0",    F_FAIL,  0);
    sb_push(1,  "D_retry0",   F_RETRY, 0);
    sb_push(1,  "D_prst1",    F_PRST,  1);
    sb_push(2,  "D_ack_end",  F_ACK,   0);
    sb_push(2,  "D_acks",     F_ACKS,  3);
    sb_push(4,  "D_prst_hi",  F_PRST,  1);
    sb_push(5,  "D_prst_lo",  F_PRST,  0);
    sb_push(68, "D_retry_pre", F_RETRY, 0);
    sb_push(69, "D_retry1",   F_RETRY, 1);
    sb_push(69, "D_prst_rt",  F_PRST,  1);
    sb_push(73, "D_prst_rt_lo", F_PRST, 0);
    sb_push(85, "D_glitch_rty", F_RETRY, 1);
    sb_push(89, "D_rdy_early", F_RDY,  0);
    sb_push(91, "D_rdy_pre",  F_RDY,   0);
    sb_push(92, "D_rdy",      F_RDY,   1);
    sb_push(92, "D_crst",     F_CRST,  0);
    sb_push(92, "D_run_rty",  F_RETRY, 1);
    relock_req = 1'b1;
    wait_to(1);  relock_req = 1'b0;
    wait_to(75); pll_locked = 1'b1;
    wait_to(80); pll_locked = 1'b0;
    wait_to(81); pll_locked = 1'b1;
    wait_to(95);

    // E: lock loss in RUN clears the retry count and re-runs the sequence.
    base = cyc;
    pll_locked = 1'b0;
    sb_push(2,  "E_rdy_hold", F_RDY,   1);
    sb_push(3,  "E_rdy0",     F_RDY,   0);
    sb_push(3,  "E_crst1",    F_CRST,  1);
    sb_push(3,  "E_prst1",    F_PRST,  1);
    sb_push(3,  "E_retry0",   F_RETRY, 0);
    sb_push(6,  "E_prst_hi",  F_PRST,  1);
    sb_push(7,  "E_prst_lo",  F_PRST,  0);
    sb_push(19, "E_rdy_pre",  F_RDY,   0);
    sb_push(20, "E_rdy",      F_RDY,   1);
    sb_push(20, "E_crst",     F_CRST,  0);
    sb_push(20, "E_acks",     F_ACKS,  3);
    wait_to(9);  pll_locked = 1'b1;
    wait_to(25);

    // F: one-cycle rst in the middle of STABLE aborts and restarts.
    base = cyc;
    sb_push(2,  "F_acks",     F_ACKS,  4);
    sb_push(9,  "F_stb_rdy",  F_RDY,   0);
    sb_push(9,  "F_stb_prst", F_PRST,  0);
    push_reset_vals(10, "F_rst");
    sb_push(13, "F_prst_hi",  F_PRST,  1);
    sb_push(14, "F_prst_lo",  F_PRST,  0);
    sb_push(14, "F_rdy_old",  F_RDY,   0);
    sb_push(22, "F_rdy_pre",  F_RDY,   0);
    sb_push(23, "F_rdy",      F_RDY,   1);
    sb_push(23, "F_crst",     F_CRST,  0);
    sb_push(23, "F_acks_end", F_ACKS,  4);
    relock_req = 1'b1;
    wait_to(1);  relock_req = 1'b0;
    wait_to(9);  rst = 1'b1;
    wait_to(10); rst = 1'b0;
    wait_to(26);

    repeat (2) @(negedge refclk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
